// File: rtl/input_event_controller_if.sv
// input_event_controller_if: Avalon-MM slave bus and level-low interrupt line of input_event_controller
interface input_event_controller_if;
  logic [1:0] avl_address;
  logic       avl_read;
  logic       avl_write;
  logic [7:0] avl_writedata;
  logic [7:0] avl_readdata;
  logic       avl_irq_n;
  modport master(output avl_address, avl_read, avl_write, avl_writedata, input avl_readdata, avl_irq_n);
  modport slave(input avl_address, avl_read, avl_write, avl_writedata, output avl_readdata, avl_irq_n);
endinterface

// File: rtl/input_event_controller.sv
// input_event_controller: keys/switches to masked edge interrupt plus ordered event queue (Avalon-MM slave)
// Ports: clk, reset (sync, active-high), keys[3:0]/switches[3:0] raw async inputs,
//   avl (slave modport): address/read/write/writedata in, readdata (1-cycle latency) and irq_n out.
// Registers: 0 INPUTS (RO), 1 MASK (RW), 2 EDGES (W1C, set wins), 3 EVENT (read pops, write bit0 flushes).
// Build option: define INPUT_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES hold filter per input.
module input_event_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  input logic [3:0] keys,
  input logic [3:0] switches,
  input_event_controller_if.slave avl
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("input_event_controller: FIFO_DEPTH must be a power of 2 >= 2 and DEBOUNCE_CYCLES >= 1");
  end
  logic [7:0] sync1, sync2, stable, stable_q, chg, mask, edges, pend, push_oh, rd_mux, ev;
  logic [3:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [2:0] push_idx;
  logic ovf, empty, full, push, pop, flush, wr_mask, wr_edges;
`ifdef INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt [8];
  // A bit is accepted only after the synchronized value has differed from stable for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          stable[i] <= sync2[i];
        end else cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) stable <= reset ? 8'h00 : sync2;
`endif
  assign chg = stable ^ stable_q;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign wr_mask = avl.avl_write && avl.avl_address == 2'd1;
  assign wr_edges = avl.avl_write && avl.avl_address == 2'd2;
  assign flush = avl.avl_write && avl.avl_address == 2'd3 && avl.avl_writedata[0];
  assign pop = avl.avl_read && avl.avl_address == 2'd3 && !empty;
  // A pop frees the slot in the same cycle, so a full queue may still accept a push.
  assign push = |pend && (!full || pop) && !flush;
  assign push_oh = pend & (~pend + 8'd1);
  always_comb begin
    push_idx = '0;
    for (int i = 7; i >= 0; i--) if (pend[i]) push_idx = 3'(i);
  end
  assign ev = empty ? 8'h00 : {1'b1, mem[rp[AW-1:0]][3], ovf, 2'b00, mem[rp[AW-1:0]][2:0]};
  assign rd_mux = avl.avl_address == 2'd0 ? stable : avl.avl_address == 2'd1 ? mask : avl.avl_address == 2'd2 ? edges : ev;
  assign avl.avl_irq_n = ~|(edges & mask);
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= {stable[push_idx], push_idx};
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable_q <= '0;
      mask <= '0;
      edges <= '0;
      pend <= '0;
      ovf <= 1'b0;
      wp <= '0;
      rp <= '0;
      avl.avl_readdata <= '0;
    end else begin
      sync1 <= {keys, switches};
      sync2 <= sync1;
      stable_q <= stable;
      if (wr_mask) mask <= avl.avl_writedata;
      edges <= (edges & ~(wr_edges ? avl.avl_writedata : 8'h00)) | chg;
      pend <= flush ? chg : (pend & ~(push ? push_oh : 8'h00)) | chg;
      // A change landing on an already pending bit coalesces into one queue entry.
      ovf <= !flush && (ovf || |(chg & pend));
      wp <= flush ? '0 : wp + PW'(push);
      rp <= flush ? '0 : rp + PW'(pop);
      if (avl.avl_read) avl.avl_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_input_event_controller.sv
// tb_input_event_controller: scoreboard bench for input_event_controller
module tb_input_event_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] keys = '0;
  logic [3:0] switches = '0;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q [$];
`ifdef INPUT_DEBOUNCE_EN
  localparam int STB = 17;
`else
  localparam int STB = 2;
`endif
  localparam int SETTLE = STB + 5;
  input_event_controller_if avl();
  input_event_controller #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .keys(keys), .switches(switches), .avl(avl)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    avl.avl_address = a;
    avl.avl_read = 1'b1;
    tick(1);
    avl.avl_read = 1'b0;
    d = avl.avl_readdata;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    avl.avl_address = a;
    avl.avl_writedata = v;
    avl.avl_write = 1'b1;
    tick(1);
    avl.avl_write = 1'b0;
  endtask
  task automatic test_reset;
    logic [7:0] d, e;
    compared++;
    if (avl.avl_readdata !== 8'h00) begin mismatched++; $display("FAIL reset_readdata: got %h want 00", avl.avl_readdata); end
    compared++;
    if (avl.avl_irq_n !== 1'b1) begin mismatched++; $display("FAIL reset_irq_n: got %b want 1", avl.avl_irq_n); end
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(8'h00);
      rd(2'(a), d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL reset_reg%0d: got %h want %h", a, d, e); end
    end
  endtask
  task automatic test_key_irq;
    logic [7:0] d, e;
    wr(2'd1, 8'h10);
    keys[0] = 1'b1;
    tick(STB + 1);
    compared++;
    if (avl.avl_irq_n !== 1'b1) begin mismatched++; $display("FAIL irq_early: got %b want 1", avl.avl_irq_n); end
    tick(1);
    compared++;
    if (avl.avl_irq_n !== 1'b0) begin mismatched++; $display("FAIL irq_assert: got %b want 0", avl.avl_irq_n); end
    exp_q.push_back(8'h10);
    exp_q.push_back(8'hC4);
    for (int a = 2; a < 4; a++) begin
      rd(2'(a), d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL key_reg%0d: got %h want %h", a, d, e); end
    end
    wr(2'd2, 8'h10);
    compared++;
    if (avl.avl_irq_n !== 1'b1) begin mismatched++; $display("FAIL irq_clear: got %b want 1", avl.avl_irq_n); end
    keys[0] = 1'b0;
    tick(SETTLE);
    exp_q.push_back(8'h84);
    rd(2'd3, d);
    e = exp_q.pop_front();
    compared++;
    if (d !== e) begin mismatched++; $display("FAIL key_release_event: got %h want %h", d, e); end
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h00);
  endtask
  task automatic test_back_to_back;
    logic [7:0] d, e;
    switches = 4'b0111;
    tick(SETTLE);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'h00);
    avl.avl_address = 2'd3;
    avl.avl_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (i == 3) avl.avl_read = 1'b0;
      d = avl.avl_readdata;
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL b2b_read%0d: got %h want %h", i, d, e); end
    end
    switches = 4'b0000;
    tick(SETTLE);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    for (int i = 0; i < 3; i++) begin
      rd(2'd3, d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL release_read%0d: got %h want %h", i, d, e); end
    end
    wr(2'd2, 8'hFF);
  endtask
  task automatic test_overflow;
    logic [7:0] d, e;
    wr(2'd3, 8'h01);
    for (int i = 0; i < 8; i++) begin
      switches[0] = ~switches[0];
      exp_q.push_back(i % 2 == 0 ? 8'hE0 : 8'hA0);
      tick(SETTLE);
    end
    switches[3] = 1'b1;
    tick(SETTLE);
    switches[3] = 1'b0;
    tick(SETTLE);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 10; i++) begin
      rd(2'd3, d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL ovf_drain%0d: got %h want %h", i, d, e); end
    end
    wr(2'd3, 8'h01);
    switches[0] = 1'b1;
    tick(SETTLE);
    exp_q.push_back(8'hC0);
    rd(2'd3, d);
    e = exp_q.pop_front();
    compared++;
    if (d !== e) begin mismatched++; $display("FAIL ovf_after_flush: got %h want %h", d, e); end
    switches[0] = 1'b0;
    tick(SETTLE);
    wr(2'd3, 8'h01);
    exp_q.push_back(8'h00);
    rd(2'd3, d);
    e = exp_q.pop_front();
    compared++;
    if (d !== e) begin mismatched++; $display("FAIL flush_empty: got %h want %h", d, e); end
    wr(2'd2, 8'hFF);
  endtask
`ifdef INPUT_DEBOUNCE_EN
  task automatic test_debounce;
    logic [7:0] d, e;
    for (int i = 0; i < 3; i++) begin
      keys[1] = 1'b1;
      tick(5);
      keys[1] = 1'b0;
      tick(5);
    end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    for (int a = 0; a < 3; a += 2) begin
      rd(2'(a), d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL bounce_reg%0d: got %h want %h", a, d, e); end
    end
    keys[1] = 1'b1;
    tick(STB);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h20);
    for (int i = 0; i < 2; i++) begin
      rd(2'd0, d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL hold_inputs%0d: got %h want %h", i, d, e); end
    end
    keys[1] = 1'b0;
    tick(SETTLE);
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'h85);
    for (int i = 0; i < 2; i++) begin
      rd(2'd3, d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL debounce_event%0d: got %h want %h", i, d, e); end
    end
    wr(2'd2, 8'hFF);
  endtask
`endif
  task automatic test_reset_mid;
    logic [7:0] d, e;
    wr(2'd1, 8'h0F);
    keys = 4'hF;
    switches = 4'hF;
    tick(STB + 2);
    exp_q.push_back(8'hFF);
    rd(2'd2, d);
    e = exp_q.pop_front();
    compared++;
    if (d !== e) begin mismatched++; $display("FAIL pre_reset_edges: got %h want %h", d, e); end
    compared++;
    if (avl.avl_irq_n !== 1'b0) begin mismatched++; $display("FAIL pre_reset_irq: got %b want 0", avl.avl_irq_n); end
    reset = 1'b1;
    keys = 4'h0;
    switches = 4'h0;
    tick(1);
    reset = 1'b0;
    compared++;
    if (avl.avl_irq_n !== 1'b1) begin mismatched++; $display("FAIL mid_reset_irq: got %b want 1", avl.avl_irq_n); end
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(8'h00);
      rd(2'(a), d);
      e = exp_q.pop_front();
      compared++;
      if (d !== e) begin mismatched++; $display("FAIL mid_reset_reg%0d: got %h want %h", a, d, e); end
    end
  endtask
  initial begin
    avl.avl_address = '0;
    avl.avl_read = 1'b0;
    avl.avl_write = 1'b0;
    avl.avl_writedata = '0;
    tick(3);
    reset = 1'b0;
    test_reset();
    test_key_irq();
    test_back_to_back();
    test_overflow();
`ifdef INPUT_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
